product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 19 +
 rtl/product_accumulator_sat_adder.sv | 21 ++
 rtl/product_accumulator.sv | 100 ++++++++++
 tb/tb_product_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator.
// The counter width is derived from the group size.
package product_accumulator_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_NUM_TERMS = 5;
  localparam int DEF_AWIDTH    = 10;

  // The counter holds 0..n-1, so ceil(log2(n)) bits are enough. It never drops below 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned adder: AWIDTH accumulator plus zero-extended DWIDTH operand.
// The result clamps to all-ones, and ovf_o flags when the clamp happens.
module sat_adder #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 8
) (
  input  logic [AWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic [AWIDTH-1:0] sum_o,
  output logic              ovf_o
);

  logic [AWIDTH:0] full;

  always_comb begin
    full  = {1'b0, a_i} + (AWIDTH+1)'(b_i);
    ovf_o = full[AWIDTH];
    sum_o = ovf_o ? '1 : full[AWIDTH-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS unsigned products into one saturating AWIDTH-bit result.
// Both the input side and the output side use valid/ready handshakes.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int NUM_TERMS = DEF_NUM_TERMS,
  parameter int AWIDTH    = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [DWIDTH-1:0] prod_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [AWIDTH-1:0] sum_data,
  output logic              sum_sat
);

  localparam int          CW   = cnt_width(NUM_TERMS);
  localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [AWIDTH-1:0] sum_q, sum_d;
  logic              sum_sat_q, sum_sat_d;

  logic [AWIDTH-1:0] add_sum;
  logic              add_ovf;

  sat_adder #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_sat_adder (
    .a_i  (acc_q),
    .b_i  (prod_data),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    sum_d     = sum_q;
    sum_sat_d = sum_sat_q;
    case (state_q)
      ACC: begin
        if (prod_valid) begin
          if (cnt_q == LAST) begin
            // The final term goes straight to the output register.
            // The group state is cleared at the same time for the next group.
            sum_d     = add_sum;
            sum_sat_d = sat_q | add_ovf;
            acc_d     = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
            state_d   = OUT;
          end else begin
            acc_d = add_sum;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      OUT: begin
        if (sum_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      sum_q     <= '0;
      sum_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      sum_q     <= sum_d;
      sum_sat_q <= sum_sat_d;
    end
  end

  assign prod_ready = (state_q == ACC);
  assign sum_valid  = (state_q == OUT);
  assign sum_data   = sum_q;
  assign sum_sat    = sum_sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and random checks of product_accumulator against a group-sum reference model.
module tb_product_accumulator;

  localparam int DW   = 8;
  localparam int NT   = 5;
  localparam int AW   = 10;
  localparam int MAXV = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prod_valid;
  logic          prod_ready;
  logic [DW-1:0] prod_data;
  logic          sum_valid;
  logic          sum_ready;
  logic [AW-1:0] sum_data;
  logic          sum_sat;

  product_accumulator #(
    .DWIDTH(DW),
    .NUM_TERMS(NT),
    .AWIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod_data (prod_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_sat   (sum_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit sat;
  } exp_t;

  int   grp[$];
  exp_t expq[$];
  bit   pending;
  int   errors = 0;
  int   checks = 0;
  int   sums_done = 0;
  int   sums_before;
  logic [31:0] got_sum;
  logic [31:0] got_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: plain integer sum of the group, clamped to the output range.
  function automatic exp_t group_result();
    exp_t r;
    int   t = 0;
    foreach (grp[i]) t += grp[i];
    r.sat = (t > MAXV);
    r.sum = r.sat ? MAXV : t;
    return r;
  endfunction

  // Called at a falling edge: drive inputs, check outputs, then advance the model across the next rising edge.
  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit sr);
    prod_valid = pv;
    prod_data  = pd;
    sum_ready  = sr;
    chk("prod_ready", prod_ready, !pending);
    chk("sum_valid", sum_valid, pending);
    if (pending) begin
      chk("sum_data", sum_data, expq[0].sum);
      chk("sum_sat", sum_sat, expq[0].sat);
    end
    if (!pending && pv) begin
      grp.push_back(int'(pd));
      if (grp.size() == NT) begin
        expq.push_back(group_result());
        grp.delete();
        pending = 1'b1;
      end
    end else if (pending && sr) begin
      got_sum = 32'(sum_data);
      got_sat = 32'(sum_sat);
      void'(expq.pop_front());
      sums_done++;
      pending = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    if (pending) step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    prod_valid = 1'b0;
    sum_ready  = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_prod_ready", prod_ready, 1);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_sum_sat", sum_sat, 0);
    grp.delete();
    expq.delete();
    pending = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    sum_ready  = 1'b0;
    pending    = 1'b0;
    @(negedge clk);
    chk("init_prod_ready", prod_ready, 1);
    chk("init_sum_valid", sum_valid, 0);
    chk("init_sum_data", sum_data, 0);
    chk("init_sum_sat", sum_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back group.
    for (int v = 10; v <= 50; v += 10) step(1'b1, DW'(v), 1'b1);
    chk("lat_sum_valid", sum_valid, 1);
    drain();
    chk("basic_sum", got_sum, 150);
    chk("basic_sat", got_sat, 0);

    // Saturating group, followed by a clean group.
    for (int i = 0; i < NT; i++) step(1'b1, 8'd255, 1'b1);
    drain();
    chk("sat_sum", got_sum, 1023);
    chk("sat_flag", got_sat, 1);
    for (int i = 0; i < NT; i++) step(1'b1, 8'd1, 1'b1);
    drain();
    chk("post_sat_sum", got_sum, 5);
    chk("post_sat_flag", got_sat, 0);

    // Output backpressure: products offered during the stall must be ignored.
    for (int i = 0; i < NT; i++) step(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("stall_sum", got_sum, 15);
    step(1'b1, 8'd4, 1'b1);
    for (int i = 1; i < NT; i++) step(1'b1, 8'd4, 1'b1);
    drain();
    chk("after_stall_sum", got_sum, 20);

    // Gaps between products.
    for (int i = 0; i < 2 * NT; i++) step((i % 2) == 0, 8'd7, 1'b1);
    drain();
    chk("gap_sum", got_sum, 35);

    // Reset in the middle of a group.
    sums_before = sums_done;
    for (int i = 0; i < 3; i++) step(1'b1, 8'd9, 1'b1);
    do_reset();
    for (int i = 0; i < NT; i++) step(1'b1, 8'd2, 1'b1);
    drain();
    chk("rst_mid_sum", got_sum, 10);
    chk("rst_mid_count", sums_done, sums_before + 1);

    // Reset while a result is pending.
    for (int i = 0; i < NT; i++) step(1'b1, 8'd50, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < NT; i++) step(1'b1, 8'd6, 1'b1);
    drain();
    chk("rst_out_sum", got_sum, 30);

    // Random handshakes over 100 groups.
    sums_before = sums_done;
    for (int cyc = 0; cyc < 20000 && (sums_done - sums_before) < 100; cyc++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom_range(0, 255)),
           $urandom_range(0, 2) != 0);
    end
    drain();
    chk("rand_groups", sums_done - sums_before, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
